// File: rtl/regfile_wport_arb_if.sv
// rtl/regfile_wport_arb_if.sv - write-port arbiter signal bundle (WB, LL, ID, RF port)
interface regfile_wport_arb_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              wb_we;
   logic [ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0] wb_wdata;
   logic              wb_stall_req;
   logic              ll_valid;
   logic [ADDR_W-1:0] ll_waddr;
   logic [DATA_W-1:0] ll_wdata;
   logic              ll_ready;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_waddr;
   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic              id_we;
   logic [ADDR_W-1:0] id_waddr;
   logic              id_stall_req;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   modport master (
      output wb_we, wb_waddr, wb_wdata, ll_valid, ll_waddr, ll_wdata,
             iss_valid, iss_waddr, re1, raddr1, re2, raddr2, id_we, id_waddr,
      input  wb_stall_req, ll_ready, id_stall_req, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  wb_we, wb_waddr, wb_wdata, ll_valid, ll_waddr, ll_wdata,
             iss_valid, iss_waddr, re1, raddr1, re2, raddr2, id_we, id_waddr,
      output wb_stall_req, ll_ready, id_stall_req, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wport_arb.sv
// rtl/regfile_wport_arb.sv - register file write-port arbiter with long-latency buffer and scoreboard
module regfile_wport_arb #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst,
   regfile_wport_arb_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic               buf_valid;
   logic [ADDR_W-1:0]  buf_waddr;
   logic [DATA_W-1:0]  buf_wdata;
   logic [REG_NUM-1:0] pending;
   logic [CNT_W-1:0]   starve_cnt;

   logic               sat;
   logic               drain;
   logic               stall_wb;
   logic               stall_id;
   logic               ll_hs;
   logic [REG_NUM-1:0] clr;
   logic [REG_NUM-1:0] set;
   logic [REG_NUM-1:0] pe;

   always_comb begin
      sat      = (starve_cnt == CNT_W'(STARVE_MAX));
      drain    = buf_valid & (~bus.wb_we | sat);
      stall_wb = buf_valid & bus.wb_we & sat;
      clr      = drain ? (REG_NUM'(1) << buf_waddr) : '0;
      // Draining register is forwarded by the register file, so it no longer blocks.
      pe       = pending & ~clr;
      stall_id = (bus.re1 & pe[bus.raddr1]) | (bus.re2 & pe[bus.raddr2]) |
                 (bus.iss_valid & pe[bus.iss_waddr]) | (bus.id_we & pe[bus.id_waddr]);
      set      = (bus.iss_valid & ~stall_id & (bus.iss_waddr != '0)) ?
                 (REG_NUM'(1) << bus.iss_waddr) : '0;
      ll_hs    = bus.ll_valid & (~buf_valid | drain);
   end

   always_comb begin
      bus.rf_we        = 1'b0;
      bus.rf_waddr     = bus.wb_waddr;
      bus.rf_wdata     = bus.wb_wdata;
      bus.ll_ready     = 1'b0;
      bus.wb_stall_req = 1'b0;
      bus.id_stall_req = 1'b0;
      if (!rst) begin
         bus.ll_ready     = ~buf_valid | drain;
         bus.wb_stall_req = stall_wb;
         bus.id_stall_req = stall_id;
         // r0 writes from the buffer are dropped here; the drain still frees the entry.
         if (drain) begin
            bus.rf_we    = (buf_waddr != '0);
            bus.rf_waddr = buf_waddr;
            bus.rf_wdata = buf_wdata;
         end else if (bus.wb_we & ~stall_wb) begin
            bus.rf_we    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid  <= 1'b0;
         buf_waddr  <= '0;
         buf_wdata  <= '0;
         pending    <= '0;
         starve_cnt <= '0;
      end else begin
         if (ll_hs) begin
            buf_valid <= 1'b1;
            buf_waddr <= bus.ll_waddr;
            buf_wdata <= bus.ll_wdata;
         end else if (drain) begin
            buf_valid <= 1'b0;
         end
         if (drain || !buf_valid) begin
            starve_cnt <= '0;
         end else if (!sat) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
         pending <= ((pending & ~clr) | set) & ~REG_NUM'(1);
      end
   end
endmodule

// File: tb/tb_regfile_wport_arb.sv
// tb/tb_regfile_wport_arb.sv - directed self-checking bench for regfile_wport_arb
module tb_regfile_wport_arb;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   regfile_wport_arb_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   regfile_wport_arb #(
      .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
      bus.ll_valid = 0; bus.ll_waddr = 0; bus.ll_wdata = 0;
      bus.iss_valid = 0; bus.iss_waddr = 0;
      bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
      bus.id_we = 0; bus.id_waddr = 0;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      bus.wb_we = 1; bus.wb_waddr = 5'd1; bus.ll_valid = 1;
      sample();
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_ll_ready", 32'(bus.ll_ready), 32'd0);
      chk("rst_wb_stall", 32'(bus.wb_stall_req), 32'd0);
      chk("rst_id_stall", 32'(bus.id_stall_req), 32'd0);
      advance();
      rst = 1'b0;
      idle_inputs();

      // Idle after reset
      bus.re1 = 1; bus.raddr1 = 5'd5; bus.re2 = 1; bus.raddr2 = 5'd9;
      sample();
      chk("idle_rf_we", 32'(bus.rf_we), 32'd0);
      chk("idle_ll_ready", 32'(bus.ll_ready), 32'd1);
      chk("idle_wb_stall", 32'(bus.wb_stall_req), 32'd0);
      chk("idle_id_stall", 32'(bus.id_stall_req), 32'd0);
      advance();

      // Issue r5: not yet pending in the issue cycle
      idle_inputs();
      bus.iss_valid = 1; bus.iss_waddr = 5'd5; bus.re1 = 1; bus.raddr1 = 5'd5;
      sample();
      chk("iss_cycle_stall", 32'(bus.id_stall_req), 32'd0);
      advance();

      idle_inputs();
      bus.re1 = 1; bus.raddr1 = 5'd5;
      bus.ll_valid = 1; bus.ll_waddr = 5'd5; bus.ll_wdata = 32'hDEADBEEF;
      sample();
      chk("raw_stall", 32'(bus.id_stall_req), 32'd1);
      chk("ll_ready_empty", 32'(bus.ll_ready), 32'd1);
      chk("ll_load_rf_we", 32'(bus.rf_we), 32'd0);
      advance();

      idle_inputs();
      bus.re1 = 1; bus.raddr1 = 5'd5;
      sample();
      chk("drain_rf_we", 32'(bus.rf_we), 32'd1);
      chk("drain_rf_waddr", 32'(bus.rf_waddr), 32'd5);
      chk("drain_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
      chk("drain_no_stall", 32'(bus.id_stall_req), 32'd0);
      advance();

      sample();
      chk("post_drain_rf_we", 32'(bus.rf_we), 32'd0);
      chk("post_drain_stall", 32'(bus.id_stall_req), 32'd0);
      advance();

      // Starvation: buffer r10 while WB writes every cycle
      idle_inputs();
      bus.wb_we = 1; bus.wb_waddr = 5'd1; bus.wb_wdata = 32'h11;
      bus.ll_valid = 1; bus.ll_waddr = 5'd10; bus.ll_wdata = 32'hA;
      sample();
      chk("starve_load_wb_waddr", 32'(bus.rf_waddr), 32'd1);
      chk("starve_load_wb_we", 32'(bus.rf_we), 32'd1);
      advance();
      for (int i = 0; i < 4; i++) begin
         bus.ll_valid = 0;
         bus.wb_waddr = 5'(2 + i); bus.wb_wdata = 32'(32'h20 + i);
         sample();
         chk("starve_wb_waddr", 32'(bus.rf_waddr), 32'(2 + i));
         chk("starve_wb_stall", 32'(bus.wb_stall_req), 32'd0);
         chk("starve_ll_ready", 32'(bus.ll_ready), 32'd0);
         advance();
      end
      bus.wb_waddr = 5'd6; bus.wb_wdata = 32'h66;
      sample();
      chk("forced_wb_stall", 32'(bus.wb_stall_req), 32'd1);
      chk("forced_rf_waddr", 32'(bus.rf_waddr), 32'd10);
      chk("forced_rf_wdata", bus.rf_wdata, 32'hA);
      chk("forced_ll_ready", 32'(bus.ll_ready), 32'd1);
      advance();
      sample();
      chk("after_forced_stall", 32'(bus.wb_stall_req), 32'd0);
      chk("after_forced_waddr", 32'(bus.rf_waddr), 32'd6);
      chk("after_forced_wdata", bus.rf_wdata, 32'h66);
      advance();

      // Back-to-back LL results r3, r4
      idle_inputs();
      bus.ll_valid = 1; bus.ll_waddr = 5'd3; bus.ll_wdata = 32'h3;
      sample();
      chk("b2b_a_ready", 32'(bus.ll_ready), 32'd1);
      chk("b2b_a_rf_we", 32'(bus.rf_we), 32'd0);
      advance();
      bus.ll_waddr = 5'd4; bus.ll_wdata = 32'h4;
      sample();
      chk("b2b_b_ready", 32'(bus.ll_ready), 32'd1);
      chk("b2b_b_rf_waddr", 32'(bus.rf_waddr), 32'd3);
      chk("b2b_b_rf_we", 32'(bus.rf_we), 32'd1);
      advance();
      bus.ll_valid = 0;
      sample();
      chk("b2b_c_rf_waddr", 32'(bus.rf_waddr), 32'd4);
      chk("b2b_c_rf_wdata", bus.rf_wdata, 32'h4);
      advance();
      sample();
      chk("b2b_d_rf_we", 32'(bus.rf_we), 32'd0);
      advance();

      // WAW and issue-to-pending on r7
      idle_inputs();
      bus.iss_valid = 1; bus.iss_waddr = 5'd7;
      sample();
      advance();
      idle_inputs();
      bus.id_we = 1; bus.id_waddr = 5'd7;
      sample();
      chk("waw_stall", 32'(bus.id_stall_req), 32'd1);
      advance();
      idle_inputs();
      bus.iss_valid = 1; bus.iss_waddr = 5'd7;
      sample();
      chk("iss_pending_stall", 32'(bus.id_stall_req), 32'd1);
      advance();
      idle_inputs();
      bus.re1 = 1; bus.raddr1 = 5'd0; bus.re2 = 1; bus.raddr2 = 5'd8;
      sample();
      chk("r0_no_stall", 32'(bus.id_stall_req), 32'd0);
      bus.raddr2 = 5'd7;
      sample();
      chk("re2_pending_stall", 32'(bus.id_stall_req), 32'd1);
      bus.ll_valid = 1; bus.ll_waddr = 5'd7; bus.ll_wdata = 32'h77;
      advance();
      idle_inputs();
      bus.id_we = 1; bus.id_waddr = 5'd7;
      sample();
      chk("r7_clear_rf_waddr", 32'(bus.rf_waddr), 32'd7);
      chk("r7_clear_no_stall", 32'(bus.id_stall_req), 32'd0);
      advance();

      // LL result to r0 is dropped but frees the buffer
      idle_inputs();
      bus.ll_valid = 1; bus.ll_waddr = 5'd0; bus.ll_wdata = 32'hBAD;
      sample();
      advance();
      idle_inputs();
      sample();
      chk("r0_drop_rf_we", 32'(bus.rf_we), 32'd0);
      chk("r0_drop_ready", 32'(bus.ll_ready), 32'd1);
      advance();
      sample();
      chk("r0_freed_ready", 32'(bus.ll_ready), 32'd1);
      advance();

      // Reset with buffer valid and r9 pending
      idle_inputs();
      bus.iss_valid = 1; bus.iss_waddr = 5'd9;
      sample();
      advance();
      idle_inputs();
      bus.wb_we = 1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h22;
      bus.ll_valid = 1; bus.ll_waddr = 5'd9; bus.ll_wdata = 32'h99;
      sample();
      advance();
      bus.ll_valid = 0;
      bus.re1 = 1; bus.raddr1 = 5'd9;
      sample();
      chk("pre_rst_ready", 32'(bus.ll_ready), 32'd0);
      chk("pre_rst_stall", 32'(bus.id_stall_req), 32'd1);
      rst = 1'b1;
      sample();
      chk("mid_rst_ready", 32'(bus.ll_ready), 32'd0);
      chk("mid_rst_stall", 32'(bus.id_stall_req), 32'd0);
      chk("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
      advance();
      rst = 1'b0;
      bus.wb_we = 0;
      sample();
      chk("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("post_rst_r9_stall", 32'(bus.id_stall_req), 32'd0);
      chk("post_rst_ready", 32'(bus.ll_ready), 32'd1);
      advance();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
